// File: rtl/ram_access_ctrl.sv
// ram_access_ctrl: load/store controller between the memory stage and a
// word-addressed RAM with one shared address port and no byte enables.
// Sub-word stores are done as read-modify-write; every completion is
// reported with a one-cycle rsp_valid pulse (rsp_err marks rejected requests).
module ram_access_ctrl #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
);

  typedef enum logic [2:0] {IDLE, LOAD, WR, RMW_RD, RMW_WR} state_t;

  state_t            state_q, state_d;
  logic [1:0]        size_q, size_d;
  logic              uns_q, uns_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       merged_q, merged_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [31:0]       rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;

  logic              req_bad;
  logic [ADDR_W-1:0] word_addr;
  logic [7:0]        byte_lane;
  logic [15:0]       half_lane;
  logic [31:0]       load_word;
  logic [31:0]       merged_word;

  assign word_addr = {addr_q[ADDR_W-1:2], 2'b00};
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

  // Reject reserved sizes and halfwords/words that are not naturally aligned.
  always_comb begin
    req_bad = 1'b0;
    case (req_size)
      2'b01:   req_bad = req_addr[0];
      2'b10:   req_bad = (req_addr[1:0] != 2'b00);
      2'b11:   req_bad = 1'b1;
      default: req_bad = 1'b0;
    endcase
  end

  // Pick the addressed lane out of the RAM word and sign/zero extend it.
  always_comb begin
    byte_lane = ram_rdata[7:0];
    case (addr_q[1:0])
      2'b00:   byte_lane = ram_rdata[7:0];
      2'b01:   byte_lane = ram_rdata[15:8];
      2'b10:   byte_lane = ram_rdata[23:16];
      default: byte_lane = ram_rdata[31:24];
    endcase
    half_lane = addr_q[1] ? ram_rdata[31:16] : ram_rdata[15:0];
    case (size_q)
      2'b00:   load_word = uns_q ? {24'h0, byte_lane} : {{24{byte_lane[7]}}, byte_lane};
      2'b01:   load_word = uns_q ? {16'h0, half_lane} : {{16{half_lane[15]}}, half_lane};
      default: load_word = ram_rdata;
    endcase
  end

  // Replace the target lane of the RAM word with the store data.
  always_comb begin
    merged_word = ram_rdata;
    if (size_q == 2'b00) begin
      case (addr_q[1:0])
        2'b00:   merged_word[7:0]   = wdata_q[7:0];
        2'b01:   merged_word[15:8]  = wdata_q[7:0];
        2'b10:   merged_word[23:16] = wdata_q[7:0];
        default: merged_word[31:24] = wdata_q[7:0];
      endcase
    end else if (addr_q[1]) begin
      merged_word[31:16] = wdata_q[15:0];
    end else begin
      merged_word[15:0] = wdata_q[15:0];
    end
  end

  // Next-state, request latching, response generation and RAM port drive.
  always_comb begin
    state_d     = state_q;
    size_d      = size_q;
    uns_d       = uns_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    merged_d    = merged_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = 32'h0;
    rsp_err_d   = 1'b0;
    req_ready   = 1'b0;
    ram_we      = 1'b0;
    ram_addr    = '0;
    ram_wdata   = 32'h0;
    case (state_q)
      IDLE: begin
        req_ready = !rst;
        if (req_valid && !rst) begin
          size_d  = req_size;
          uns_d   = req_unsigned;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          if (req_bad) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
          end else if (!req_we) begin
            state_d = LOAD;
          end else if (req_size == 2'b10) begin
            state_d = WR;
          end else begin
            state_d = RMW_RD;
          end
        end
      end
      LOAD: begin
        ram_addr    = word_addr;
        rsp_rdata_d = load_word;
        rsp_valid_d = 1'b1;
        state_d     = IDLE;
      end
      WR: begin
        ram_we      = 1'b1;
        ram_addr    = word_addr;
        ram_wdata   = wdata_q;
        rsp_valid_d = 1'b1;
        state_d     = IDLE;
      end
      RMW_RD: begin
        ram_addr = word_addr;
        merged_d = merged_word;
        state_d  = RMW_WR;
      end
      RMW_WR: begin
        ram_we      = 1'b1;
        ram_addr    = word_addr;
        ram_wdata   = merged_q;
        rsp_valid_d = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (rst) begin
      ram_we    = 1'b0;
      ram_addr  = '0;
      ram_wdata = 32'h0;
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      size_q      <= 2'b00;
      uns_q       <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= 32'h0;
      merged_q    <= 32'h0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'h0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      size_q      <= size_d;
      uns_q       <= uns_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      merged_q    <= merged_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

endmodule

// File: tb/tb_ram_access_ctrl.sv
// Testbench for ram_access_ctrl: behavioural RAM, reference memory image and
// a response scoreboard with expected arrival cycles.
module tb_ram_access_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        ram_we;
  logic [31:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] mem     [64];
  logic [31:0] ref_mem [64];
  int          cyc = 0;
  int          assertions = 0;
  int          failures = 0;
  int          writes_seen = 0;
  int          writes_expected = 0;
  bit          started = 1'b0;

  ram_access_ctrl #(.ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural RAM: combinational read (zero while writing), writes gated by reset.
  assign ram_rdata = ram_we ? 32'h0 : mem[ram_addr[7:2]];
  always @(posedge clk) begin
    if (ram_we && !rst) mem[ram_addr[7:2]] <= ram_wdata;
  end

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    assertions++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h at cycle %0d", tag, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] expLoad(input logic [31:0] w, input logic [1:0] sz,
                                          input logic uns, input logic [1:0] lo);
    logic [31:0] sh;
    sh = w >> (8 * lo);
    if (sz == 2'b00) return uns ? (sh & 32'hFF) : 32'(signed'(sh[7:0]));
    if (sz == 2'b01) return uns ? (sh & 32'hFFFF) : 32'(signed'(sh[15:0]));
    return w;
  endfunction

  // Drive one request (entered at posedge+1) and queue its expected response.
  task automatic applyStimulus(input logic we, input logic [1:0] sz, input logic uns,
                               input logic [31:0] a, input logic [31:0] wd,
                               output int acc_cyc);
    exp_t        e;
    logic        bad;
    int          lat;
    bit          ok;
    logic [31:0] m;
    ok = 1'b0;
    acc_cyc = -1;
    req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
    req_addr = a; req_wdata = wd;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (req_ready) begin
        acc_cyc = cyc;
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    if (!ok) begin
      checkOutput("accept_timeout", 32'h0, 32'h1);
    end else begin
      bad = (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00);
      e.err = bad;
      e.rdata = 32'h0;
      if (bad) lat = 0;
      else if (!we || sz == 2'b10) lat = 1;
      else lat = 2;
      if (!bad && !we) e.rdata = expLoad(ref_mem[a[7:2]], sz, uns, a[1:0]);
      if (!bad && we) begin
        writes_expected++;
        m = (sz == 2'b00) ? 32'hFF : (sz == 2'b01) ? 32'hFFFF : 32'hFFFF_FFFF;
        ref_mem[a[7:2]] = (ref_mem[a[7:2]] & ~(m << (8 * a[1:0]))) | ((wd & m) << (8 * a[1:0]));
      end
      e.cyc = acc_cyc + 1 + lat;
      sb.push_back(e);
    end
  endtask

  task automatic waitDone();
    req_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (sb.size() == 0) break;
      @(posedge clk); #1;
    end
    checkOutput("drain", sb.size(), 0);
  endtask

  // Per-cycle monitor: ready protocol, address alignment, idle zeros, scoreboard.
  always @(negedge clk) begin
    exp_t e;
    logic exp_ready;
    if (started) begin
      if (ram_we) writes_seen++;
      checkOutput("ram_addr_align", ram_addr & 32'hFFFF_FF03, 32'h0);
      exp_ready = !rst && !(sb.size() > 0 && !sb[0].err && sb[0].cyc > cyc);
      checkOutput("req_ready", {31'h0, req_ready}, {31'h0, exp_ready});
      if (rsp_valid) begin
        if (sb.size() == 0) begin
          checkOutput("unexpected_rsp", 32'h1, 32'h0);
        end else begin
          e = sb.pop_front();
          checkOutput("rsp_rdata", rsp_rdata, e.rdata);
          checkOutput("rsp_err", {31'h0, rsp_err}, {31'h0, e.err});
          checkOutput("rsp_cycle", cyc, e.cyc);
        end
      end else begin
        checkOutput("idle_rdata", rsp_rdata, 32'h0);
        checkOutput("idle_err", {31'h0, rsp_err}, 32'h0);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int a0, a1, a2, a3, w0;
    logic [31:0] saved;
    for (int i = 0; i < 64; i++) begin
      mem[i] = 32'h0;
      ref_mem[i] = 32'h0;
    end
    mem[8]  = 32'h1122_3344; ref_mem[8]  = 32'h1122_3344;
    mem[12] = 32'h8000_FF7F; ref_mem[12] = 32'h8000_FF7F;
    mem[20] = 32'hCAFE_F00D; ref_mem[20] = 32'hCAFE_F00D;

    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_ready", {31'h0, req_ready}, 32'h0);
    checkOutput("reset_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    checkOutput("reset_ram_we", {31'h0, ram_we}, 32'h0);
    checkOutput("reset_ram_addr", ram_addr, 32'h0);
    checkOutput("reset_ram_wdata", ram_wdata, 32'h0);
    @(posedge clk); #1;
    started = 1'b1;
    rst = 1'b0;

    $display("[TB] word store then load");
    applyStimulus(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF, a0);
    waitDone();
    checkOutput("ram_word4", mem[4], 32'hDEAD_BEEF);
    applyStimulus(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, a0);
    waitDone();

    $display("[TB] byte read-modify-write");
    w0 = writes_seen;
    applyStimulus(1'b1, 2'b00, 1'b0, 32'h22, 32'h0000_00AA, a0);
    waitDone();
    checkOutput("ram_word8", mem[8], 32'h11AA_3344);
    checkOutput("rmw_we_cycles", writes_seen - w0, 1);

    $display("[TB] extension loads back-to-back");
    applyStimulus(1'b0, 2'b00, 1'b0, 32'h30, 32'h0, a0);
    applyStimulus(1'b0, 2'b00, 1'b0, 32'h31, 32'h0, a1);
    applyStimulus(1'b0, 2'b01, 1'b1, 32'h32, 32'h0, a2);
    applyStimulus(1'b0, 2'b01, 1'b0, 32'h32, 32'h0, a3);
    waitDone();
    checkOutput("b2b_accept1", a1, a0 + 2);
    checkOutput("b2b_accept2", a2, a1 + 2);
    checkOutput("b2b_accept3", a3, a2 + 2);

    $display("[TB] misaligned and reserved requests");
    w0 = writes_seen;
    applyStimulus(1'b1, 2'b01, 1'b0, 32'h41, 32'h1234, a0);
    applyStimulus(1'b1, 2'b10, 1'b0, 32'h42, 32'h5555_AAAA, a1);
    applyStimulus(1'b0, 2'b11, 1'b0, 32'h40, 32'h0, a2);
    waitDone();
    checkOutput("err_accept1", a1, a0 + 1);
    checkOutput("err_accept2", a2, a1 + 1);
    checkOutput("err_no_write", writes_seen - w0, 0);
    checkOutput("ram_word16", mem[16], 32'h0);

    $display("[TB] reset during read-modify-write");
    saved = ref_mem[20];
    w0 = writes_expected;
    applyStimulus(1'b1, 2'b00, 1'b0, 32'h51, 32'h77, a0);
    req_valid = 1'b0;
    rst = 1'b1;
    sb.delete();
    ref_mem[20] = saved;
    writes_expected = w0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("post_reset_ready", {31'h0, req_ready}, 32'h1);
    @(posedge clk); #1;
    checkOutput("ram_word20", mem[20], 32'hCAFE_F00D);

    $display("[TB] mixed back-to-back traffic");
    applyStimulus(1'b1, 2'b01, 1'b0, 32'h52, 32'h0000_BEEF, a0);
    applyStimulus(1'b0, 2'b10, 1'b0, 32'h50, 32'h0, a1);
    applyStimulus(1'b1, 2'b00, 1'b0, 32'h53, 32'h0000_0012, a2);
    applyStimulus(1'b0, 2'b00, 1'b1, 32'h53, 32'h0, a3);
    waitDone();
    checkOutput("mix_accept1", a1, a0 + 3);
    checkOutput("mix_accept3", a3, a2 + 3);
    checkOutput("ram_word20_final", mem[20], 32'h12EF_F00D);
    checkOutput("write_count", writes_seen, writes_expected);

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
